// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush control: load-use and HI/LO-busy hazards plus the multiply/divide busy counter.
// Optional `PIPE_STALL_CNT_EN adds a 32-bit stall_cnt output counting stalled cycles.
module pipe_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs_addr,
    input  logic [4:0]  d_rt_addr,
    input  logic        d_rs_use,
    input  logic        d_rt_use,
    input  logic        e_load,
    input  logic [4:0]  e_wa,
    input  logic        d_md_op,
    input  logic        e_md_start,
    input  logic        e_md_is_div,
    input  logic        exc_req,
    output logic        f_we,
    output logic        d_we,
    output logic        e_flush,
    output logic        md_busy,
`ifdef PIPE_STALL_CNT_EN
    output logic [3:0]  md_cnt,
    output logic [31:0] stall_cnt
`else
    output logic [3:0]  md_cnt
`endif
);

    // Busy-cycle counts must fit the 4-bit counter (valid range 1..15).
    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        MD_RUN
    } md_state_t;

    md_state_t state;

    logic rs_hit;
    logic rt_hit;
    logic load_use;
    logic md_stall;
    logic stall;

    // A start seen while already running is ignored, and exc_req never aborts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            md_cnt  <= 4'd0;
            md_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (e_md_start) begin
                        md_cnt  <= e_md_is_div ? DIV_LD : MULT_LD;
                        state   <= MD_RUN;
                        md_busy <= 1'b1;
                    end
                end
                MD_RUN: begin
                    if (md_cnt == 4'd1) begin
                        md_cnt  <= 4'd0;
                        state   <= IDLE;
                        md_busy <= 1'b0;
                    end else begin
                        md_cnt  <= md_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    md_cnt  <= 4'd0;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

    assign rs_hit   = d_rs_use && (d_rs_addr == e_wa);
    assign rt_hit   = d_rt_use && (d_rt_addr == e_wa);
    assign load_use = e_load && (e_wa != 5'd0) && (rs_hit || rt_hit);
    assign md_stall = d_md_op && (md_busy || e_md_start);

    // An exception overrides any hazard so the pipeline registers can run their own flush.
    assign stall   = (load_use || md_stall) && !exc_req;
    assign f_we    = !stall;
    assign d_we    = !stall;
    assign e_flush = stall;

`ifdef PIPE_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 32'd0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
